// File: rtl/req_fifo_bank.sv
// rtl/req_fifo_bank.sv - per-requester FIFO bank feeding a round-robin arbiter
//
// Purpose: NCH independent circular FIFOs (2**AW deep, DW wide). Each channel's
// non-empty flag is one bit of the arbiter request vector. The arbiter's
// one-hot grant selects the channel whose head word appears on the read port
// (first-word fall-through), and i_pop consumes that word.
//
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rstn   asynchronous active-low reset (pointers and error flag only)
//   i_push   per-channel write strobe
//   i_wdata  write data, channel k at [k*DW +: DW]
//   o_full   per-channel full flag (from registered pointers)
//   o_req    per-channel non-empty flag (from registered pointers)
//   i_gnt    one-hot grant, all-zero = no grant
//   i_pop    consume head word of granted channel
//   o_rdata  head word of granted channel, 0 when not valid
//   o_rvld   granted channel is non-empty
//   o_err    sticky protocol error: push to full, or illegal pop
module req_fifo_bank #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int AW  = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [NCH-1:0]    i_push,
    input  logic [NCH*DW-1:0] i_wdata,
    output logic [NCH-1:0]    o_full,
    output logic [NCH-1:0]    o_req,
    input  logic [NCH-1:0]    i_gnt,
    input  logic              i_pop,
    output logic [DW-1:0]     o_rdata,
    output logic              o_rvld,
    output logic              o_err
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0]   wptr_q [NCH];
    logic [AW:0]   wptr_d [NCH];
    logic [AW:0]   rptr_q [NCH];
    logic [AW:0]   rptr_d [NCH];
    logic [DW-1:0] mem_q  [NCH][DEPTH];
    logic          err_q;
    logic          err_d;

    logic [NCH-1:0] empty;
    logic [NCH-1:0] full;
    logic [NCH-1:0] push_ok;
    logic [NCH-1:0] pop_ok;
    logic           gnt_onehot;
    logic           push_bad;
    logic           pop_bad;

    // Status comes only from registered pointers, so o_req/o_full never
    // depend combinationally on this cycle's push/pop.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            empty[k] = (wptr_q[k] == rptr_q[k]);
            full[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                       (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
        end
    end

    assign o_req  = ~empty;
    assign o_full = full;
    assign o_err  = err_q;

    // x & (x-1) clears the lowest set bit; zero result with x != 0 is one-hot.
    assign gnt_onehot = (i_gnt != '0) &&
                        ((i_gnt & (i_gnt - {{(NCH-1){1'b0}}, 1'b1})) == '0);

    // Fullness is judged on pre-edge pointers: a concurrent pop does not
    // make room for a push in the same cycle.
    assign push_ok  = i_push & ~full;
    assign push_bad = |(i_push & full);
    assign pop_ok   = (i_pop && gnt_onehot) ? (i_gnt & ~empty) : '0;
    assign pop_bad  = i_pop && (pop_ok == '0);
    assign err_d    = err_q | push_bad | pop_bad;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            wptr_d[k] = wptr_q[k];
            rptr_d[k] = rptr_q[k];
            if (push_ok[k]) begin
                wptr_d[k] = wptr_q[k] + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok[k]) begin
                rptr_d[k] = rptr_q[k] + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < NCH; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
            end
            err_q <= err_d;
        end
    end

    // Storage is intentionally not reset; empty pointers hide stale words.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (push_ok[k]) begin
                mem_q[k][wptr_q[k][AW-1:0]] <= i_wdata[k*DW +: DW];
            end
        end
    end

    // First-word fall-through read mux; no bypass from the write port.
    always_comb begin
        o_rdata = '0;
        o_rvld  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_onehot && i_gnt[k] && !empty[k]) begin
                o_rdata = mem_q[k][rptr_q[k][AW-1:0]];
                o_rvld  = 1'b1;
            end
        end
    end

endmodule
